line_burst_adaptor: RTL and testbench
=====================================

Name: line_burst_adaptor

Overview:
Memory-side responder for the L2 cache's physical-memory port. It accepts one 256-bit cacheline read or write request on the cache-facing interface (read/write held until resp, single-cycle resp). It services the request as a 4-beat, 64-bit burst on the DRAM-facing interface. It sits between l2 cache control/datapath and the physical memory model or arbiter.

Parameters:
LINE_W, 256, cacheline width in bits
BEAT_W, 64, burst beat width in bits
BEATS, LINE_W/BEAT_W (4), beats per line; must be a power of two

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
line_address_i  in  32  cache line address; bits [4:0] ignored
line_read_i  in  1  line read request, held until line_resp_o
line_write_i  in  1  line write request, held until line_resp_o
line_wdata_i  in  LINE_W  write line, valid while line_write_i is high
line_rdata_o  out  LINE_W  assembled read line
line_resp_o  out  1  one-cycle completion pulse
burst_address_o  out  32  line-aligned address {addr[31:5],5'b0}
burst_read_o  out  1  burst read request, held for all beats
burst_write_o  out  1  burst write request, held for all beats
burst_wdata_o  out  BEAT_W  current write beat
burst_rdata_i  in  BEAT_W  read beat, valid when burst_resp_i is high
burst_resp_i  in  1  per-beat acknowledge

Behaviour:
- Reset (rst=0, async): state IDLE, beat count 0, all outputs 0 (line_rdata_o=0, burst_address_o=0).
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - If line_write_i=1, capture address and line_wdata_i, then go to WR_BURST.
  - Else if line_read_i=1, capture address, then go to RD_BURST.
  - Simultaneous read and write is illegal. The write is taken.
- Captured address is registered; burst_address_o is stable from the cycle after capture until DONE.
- RD_BURST:
  - burst_read_o=1.
  - On each cycle with burst_resp_i=1, store burst_rdata_i into line_rdata_o[count*64 +: 64] and increment count.
  - Beat 0 is the least-significant 64 bits.
  - On the beat where count==BEATS-1, go to DONE and reset count to 0.
- WR_BURST:
  - burst_write_o=1 and burst_wdata_o = captured_line[count*64 +: 64].
  - Advance on burst_resp_i with the same count rules as RD_BURST.
- DONE:
  - line_resp_o=1 for exactly one cycle, burst_read_o and burst_write_o both 0, then go to IDLE.
  - The requester drops its request in the cycle after resp, so IDLE never re-triggers on a stale request.
- line_rdata_o holds its value until the next read burst overwrites it. A write does not alter it.
- burst_resp_i in IDLE or DONE is ignored and has no side effects.
- Latency:
  - Capture edge, then BEATS resp cycles, then one DONE cycle.
  - Minimum from request to line_resp_o is BEATS+1 cycles after the request is sampled.
- burst_resp_i may stall for any number of cycles between beats. All burst outputs hold steady during a stall.
- Line inputs changing mid-burst are ignored, because the request was captured.
- Reset mid-burst:
  - Immediate return to IDLE with outputs cleared.
  - The partial line in line_rdata_o is cleared to 0.
  - No resp is issued.
- The count is log2(BEATS) bits wide and wraps naturally. The last-beat check uses an explicit compare, not the wrap.

Decomposition:
- Shared package line_burst_pkg holds:
  - LINE_W, BEAT_W, BEATS;
  - beat_idx_t (log2 BEATS bits);
  - the state enum.
- Use the codebase's rv32i_word type for addresses.
- One sub-module, line_beat_buffer: a LINE_W register with beat-indexed load (read assembly) and beat-indexed select (write slicing), with asynchronous clear.
- The FSM and counter stay in line_burst_adaptor.

Test Plan:
- Read, no stalls:
  - Stimulus: line_read_i with address 0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with resp every cycle.
  - Required: burst_address_o=0x0000_1220; line_rdata_o={0x44..44,0x33..33,0x22..22,0x11..11}; line_resp_o high for exactly 1 cycle, 5 cycles after the request is sampled.
- Write with stalls:
  - Stimulus: line_wdata_i = 256'h0123...cdef; burst_resp_i has 3 idle cycles between beats.
  - Required: burst_wdata_o equals bits [63:0], [127:64], [191:128], [255:192] in order, each held through its stall; burst_write_o stays high until the last beat.
- Simultaneous read and write in IDLE:
  - Required: WR_BURST is entered, burst_read_o never rises, and line_rdata_o is unchanged.
- Stray resp:
  - Stimulus: burst_resp_i pulsed in IDLE and in DONE.
  - Required: count remains 0, no resp, and line_rdata_o is unchanged.
- Reset mid-burst:
  - Stimulus: rst low asynchronously after 2 read beats.
  - Required: all outputs 0 immediately; after release, a new read completes correctly from beat 0.
- Back-to-back requests:
  - Stimulus: a read completes; the requester drops read and asserts write 1 cycle later.
  - Required: exactly one resp per request, with no spurious second burst.

Source files
------------

// File: rtl/line_burst_pkg.sv
// Shared widths, beat index type, address type and FSM state encoding for the
// cacheline-to-burst adaptor.
package line_burst_pkg;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int IDX_W  = $clog2(BEATS);

    typedef logic [IDX_W-1:0] beat_idx_t;
    typedef logic [31:0]      rv32i_word;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_BURST = 2'd1,
        ST_WR_BURST = 2'd2,
        ST_DONE     = 2'd3
    } burst_state_e;

    // Clears the byte-in-line offset so the burst starts on a line boundary.
    function automatic rv32i_word line_align(input rv32i_word addr);
        return addr & ~rv32i_word'(LINE_W / 8 - 1);
    endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// One cacheline register split into beat slices: whole-line load, single-beat
// load at a beat index, and beat-indexed readout.
module line_beat_buffer
    import line_burst_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     line_load,
    input  logic [LINE_W-1:0]        line_data,
    input  logic                     beat_load,
    input  logic [IDX_W-1:0]         beat_idx,
    input  logic [BEAT_W-1:0]        beat_data,
    output logic [LINE_W-1:0]        line_q,
    output logic [BEAT_W-1:0]        beat_q
);

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            logic [BEAT_W-1:0] slice_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    slice_reg <= '0;
                end else if (line_load) begin
                    slice_reg <= line_data[gi*BEAT_W +: BEAT_W];
                end else if (beat_load && (beat_idx == beat_idx_t'(gi))) begin
                    slice_reg <= beat_data;
                end
            end

            assign line_q[gi*BEAT_W +: BEAT_W] = slice_reg;
        end
    endgenerate

    assign beat_q = line_q[beat_idx*BEAT_W +: BEAT_W];

endmodule

// File: rtl/line_burst_adaptor.sv
// Services one 256-bit cacheline read/write from the L2 as a 4-beat 64-bit
// burst on the DRAM side, then pulses line_resp_o for one cycle.
module line_burst_adaptor
    import line_burst_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       line_address_i,
    input  logic              line_read_i,
    input  logic              line_write_i,
    input  logic [LINE_W-1:0] line_wdata_i,
    output logic [LINE_W-1:0] line_rdata_o,
    output logic              line_resp_o,
    output logic [31:0]       burst_address_o,
    output logic              burst_read_o,
    output logic              burst_write_o,
    output logic [BEAT_W-1:0] burst_wdata_o,
    input  logic [BEAT_W-1:0] burst_rdata_i,
    input  logic              burst_resp_i
);

    localparam logic [1:0] IDLE     = ST_IDLE;
    localparam logic [1:0] RD_BURST = ST_RD_BURST;
    localparam logic [1:0] WR_BURST = ST_WR_BURST;
    localparam logic [1:0] DONE     = ST_DONE;

    localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

    logic [1:0] state_reg, state_next;
    beat_idx_t  count_reg, count_next;
    rv32i_word  addr_reg, addr_next;

    logic              wline_load;
    logic              rbeat_load;
    logic [BEAT_W-1:0] wbeat;
    logic [LINE_W-1:0] wr_line_unused;
    logic [BEAT_W-1:0] rd_beat_unused;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        addr_next  = addr_reg;
        wline_load = 1'b0;
        rbeat_load = 1'b0;
        case (state_reg)
            IDLE: begin
                // A write wins if the requester illegally raises both.
                if (line_write_i) begin
                    addr_next  = line_align(line_address_i);
                    wline_load = 1'b1;
                    state_next = WR_BURST;
                end else if (line_read_i) begin
                    addr_next  = line_align(line_address_i);
                    state_next = RD_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if (burst_resp_i) begin
                    rbeat_load = (state_reg == RD_BURST);
                    if (count_reg == LAST_BEAT) begin
                        count_next = '0;
                        state_next = DONE;
                    end else begin
                        count_next = count_reg + beat_idx_t'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            addr_reg  <= addr_next;
        end
    end

    // Read assembly lives apart from the write capture so a write never
    // disturbs the last line returned to the cache.
    line_beat_buffer u_rd_buf (
        .clk       (clk),
        .rst       (rst),
        .line_load (1'b0),
        .line_data ('0),
        .beat_load (rbeat_load),
        .beat_idx  (count_reg),
        .beat_data (burst_rdata_i),
        .line_q    (line_rdata_o),
        .beat_q    (rd_beat_unused)
    );

    line_beat_buffer u_wr_buf (
        .clk       (clk),
        .rst       (rst),
        .line_load (wline_load),
        .line_data (line_wdata_i),
        .beat_load (1'b0),
        .beat_idx  (count_reg),
        .beat_data ('0),
        .line_q    (wr_line_unused),
        .beat_q    (wbeat)
    );

    assign burst_address_o = addr_reg;
    assign burst_read_o    = (state_reg == RD_BURST);
    assign burst_write_o   = (state_reg == WR_BURST);
    assign line_resp_o     = (state_reg == DONE);
    assign burst_wdata_o   = burst_write_o ? wbeat : '0;

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed bench for line_burst_adaptor: a requester/DRAM model drives each
// request, expected lines and write beats flow through scoreboard queues.
module tb_line_burst_adaptor;
    import line_burst_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       line_address_i;
    logic              line_read_i;
    logic              line_write_i;
    logic [LINE_W-1:0] line_wdata_i;
    logic [LINE_W-1:0] line_rdata_o;
    logic              line_resp_o;
    logic [31:0]       burst_address_o;
    logic              burst_read_o;
    logic              burst_write_o;
    logic [BEAT_W-1:0] burst_wdata_o;
    logic [BEAT_W-1:0] burst_rdata_i;
    logic              burst_resp_i;

    line_burst_adaptor dut (
        .clk             (clk),
        .rst             (rst),
        .line_address_i  (line_address_i),
        .line_read_i     (line_read_i),
        .line_write_i    (line_write_i),
        .line_wdata_i    (line_wdata_i),
        .line_rdata_o    (line_rdata_o),
        .line_resp_o     (line_resp_o),
        .burst_address_o (burst_address_o),
        .burst_read_o    (burst_read_o),
        .burst_write_o   (burst_write_o),
        .burst_wdata_o   (burst_wdata_o),
        .burst_rdata_i   (burst_rdata_i),
        .burst_resp_i    (burst_resp_i)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int resp_count = 0;
    int exp_resps  = 0;

    logic [LINE_W-1:0] rq[$];
    logic [BEAT_W-1:0] wq[$];
    logic [LINE_W-1:0] last_rdata;

    always @(posedge clk) begin
        if (rst && line_resp_o) resp_count++;
    end

    task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                         input logic [LINE_W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request from IDLE, plays the DRAM side with `stall` idle
    // cycles between beats, and returns the negedge index (after the capture
    // edge) at which line_resp_o was seen.
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [LINE_W-1:0] ldata, input int stall,
                           input bit stray_done, output int lat);
        int n = 0;
        int b = 0;
        int gap = stall;
        logic is_wr = wr;
        logic [31:0] exp_addr = addr & 32'hFFFF_FFE0;
        logic [LINE_W-1:0] exp_line;
        lat = -1;
        exp_resps++;
        if (is_wr) begin
            for (int i = 0; i < BEATS; i++) wq.push_back(ldata[i*BEAT_W +: BEAT_W]);
        end else begin
            rq.push_back(ldata);
        end
        line_read_i    = rd;
        line_write_i   = wr;
        line_address_i = addr;
        line_wdata_i   = is_wr ? ldata : '0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (line_resp_o) begin
                lat = n;
                break;
            end
            check("burst_read_o", burst_read_o, !is_wr);
            check("burst_write_o", burst_write_o, is_wr);
            check("burst_address_o", burst_address_o, exp_addr);
            if (is_wr && wq.size() > 0) check("burst_wdata_o", burst_wdata_o, wq[0]);
            if (n == 2) begin
                line_address_i = ~addr;
                line_wdata_i   = ~ldata;
            end
            if (b < BEATS && gap >= stall) begin
                burst_resp_i  = 1'b1;
                burst_rdata_i = is_wr ? 64'hDEAD_BEEF_DEAD_BEEF : ldata[b*BEAT_W +: BEAT_W];
                b++;
                gap = 0;
                if (is_wr) void'(wq.pop_front());
            end else begin
                burst_resp_i  = 1'b0;
                burst_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
                gap++;
            end
        end
        if (lat < 0) begin
            check("resp_timeout", line_resp_o, 1'b1);
        end else begin
            check("done_read_low", burst_read_o, 1'b0);
            check("done_write_low", burst_write_o, 1'b0);
            if (is_wr) begin
                check("rdata_hold_on_write", line_rdata_o, last_rdata);
            end else if (rq.size() > 0) begin
                exp_line = rq.pop_front();
                check("line_rdata_o", line_rdata_o, exp_line);
                last_rdata = exp_line;
            end
        end
        line_read_i   = 1'b0;
        line_write_i  = 1'b0;
        burst_resp_i  = stray_done;
        burst_rdata_i = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        check("resp_one_cycle", line_resp_o, 1'b0);
        check("idle_read_low", burst_read_o, 1'b0);
        check("idle_write_low", burst_write_o, 1'b0);
        check("idle_rdata", line_rdata_o, last_rdata);
        burst_resp_i = 1'b0;
        $display("txn %s addr=%h stall=%0d lat=%0d", is_wr ? "WR" : "RD", addr, stall, lat);
    endtask

    localparam logic [LINE_W-1:0] RLINE1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    localparam logic [LINE_W-1:0] WLINE  =
        256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
    localparam logic [LINE_W-1:0] RLINE2 =
        256'ha5a5a5a5_00000001_5a5a5a5a_00000002_c3c3c3c3_00000003_3c3c3c3c_00000004;
    localparam logic [LINE_W-1:0] RLINE3 =
        256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0001;

    initial begin
        int lat;
        rst            = 1'b0;
        line_address_i = '0;
        line_read_i    = 1'b0;
        line_write_i   = 1'b0;
        line_wdata_i   = '0;
        burst_rdata_i  = '0;
        burst_resp_i   = 1'b0;
        last_rdata     = '0;

        // Reset state.
        #12;
        check("rst_rdata", line_rdata_o, '0);
        check("rst_addr", burst_address_o, '0);
        check("rst_read", burst_read_o, 1'b0);
        check("rst_write", burst_write_o, 1'b0);
        check("rst_resp", line_resp_o, 1'b0);
        check("rst_wdata", burst_wdata_o, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Read, no stalls: resp seen BEATS+1 cycles after the capture edge.
        run_req(1'b1, 1'b0, 32'h0000_1234, RLINE1, 0, 1'b0, lat);
        check("read_latency", lat, BEATS + 1);

        // Write with 3 idle cycles between beats.
        run_req(1'b0, 1'b1, 32'h8000_0047, WLINE, 3, 1'b0, lat);
        check("write_stall_latency", lat, 14);

        // Simultaneous read and write: write taken, stray resp in DONE.
        run_req(1'b1, 1'b1, 32'h0000_2000, ~WLINE, 0, 1'b1, lat);
        check("rdwr_latency", lat, BEATS + 1);

        // Stray resp while IDLE.
        for (int i = 0; i < 3; i++) begin
            burst_resp_i  = 1'b1;
            burst_rdata_i = 64'hCAFE_CAFE_CAFE_CAFE;
            @(negedge clk);
            check("stray_idle_resp", line_resp_o, 1'b0);
            check("stray_idle_read", burst_read_o, 1'b0);
            check("stray_idle_rdata", line_rdata_o, last_rdata);
        end
        burst_resp_i = 1'b0;
        @(negedge clk);

        // A read right after the strays must still fill from beat 0.
        run_req(1'b1, 1'b0, 32'h0000_3fff, RLINE2, 1, 1'b1, lat);
        check("read_after_stray_latency", lat, 8);

        // Reset asserted asynchronously after two read beats.
        line_read_i    = 1'b1;
        line_address_i = 32'h0000_0040;
        @(negedge clk);
        burst_resp_i  = 1'b1;
        burst_rdata_i = 64'h0102_0304_0506_0708;
        @(negedge clk);
        burst_rdata_i = 64'h1112_1314_1516_1718;
        @(negedge clk);
        burst_resp_i  = 1'b0;
        check("partial_rdata", line_rdata_o,
              {RLINE2[255:128], 64'h1112_1314_1516_1718, 64'h0102_0304_0506_0708});
        #2 rst = 1'b0;
        #1;
        check("midrst_rdata", line_rdata_o, '0);
        check("midrst_addr", burst_address_o, '0);
        check("midrst_read", burst_read_o, 1'b0);
        check("midrst_resp", line_resp_o, 1'b0);
        line_read_i = 1'b0;
        last_rdata  = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_rdata", line_rdata_o, '0);
        run_req(1'b1, 1'b0, 32'h0000_0040, RLINE3, 0, 1'b0, lat);
        check("post_rst_latency", lat, BEATS + 1);

        // Back-to-back: write raised one cycle after the read's resp.
        run_req(1'b1, 1'b0, 32'hffff_ffe0, RLINE1 ^ RLINE3, 0, 1'b0, lat);
        run_req(1'b0, 1'b1, 32'h1234_5678, RLINE2, 0, 1'b0, lat);
        check("b2b_write_latency", lat, BEATS + 1);
        repeat (3) begin
            @(negedge clk);
            check("b2b_no_spurious_read", burst_read_o, 1'b0);
            check("b2b_no_spurious_write", burst_write_o, 1'b0);
        end
        check("resp_count", resp_count, exp_resps);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
